// File: rtl/stroke_write_arbiter.sv
// Brush-stroke canvas write arbiter: NREQ requesters share the canvas RAM round-robin
// inside a per-frame write window; a clear request sweeps the canvas to zero.
// Optional feature macro: STROKE_ERASE_EN (req_erase forces black writes).
package stroke_write_arbiter_pkg;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] color;
    logic       erase;
  } stroke_req_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [2:0]  wdata;
    logic        ok;
  } stroke_wr_t;
endpackage

// Per-requester decode: range check, canvas address and write data.
module stroke_req_lane
  import stroke_write_arbiter_pkg::*;
(
  input  stroke_req_t i_req,
  output stroke_wr_t  o_wr
);
  always_comb begin
    o_wr.ok   = (i_req.x < 10'd640) && (i_req.y < 10'd480);
    o_wr.addr = {i_req.y[8:3], i_req.x[9:3]};
`ifdef STROKE_ERASE_EN
    o_wr.wdata = i_req.erase ? 3'b000 : i_req.color;
`else
    o_wr.wdata = i_req.color;
`endif
  end

`ifndef STROKE_ERASE_EN
  logic w_unused_erase;
  assign w_unused_erase = i_req.erase;
`endif
endmodule

module stroke_write_arbiter
  import stroke_write_arbiter_pkg::*;
#(
  parameter int WIN  = 64,
  parameter int NREQ = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 refr_tick,
  input  logic [NREQ-1:0]      req,
  input  logic [10*NREQ-1:0]   req_x,
  input  logic [10*NREQ-1:0]   req_y,
  input  logic [3*NREQ-1:0]    req_color,
  input  logic [NREQ-1:0]      req_erase,
  input  logic                 clear_req,
  output logic [NREQ-1:0]      grant,
  output logic                 ram_we,
  output logic [12:0]          ram_addr,
  output logic [2:0]           ram_wdata,
  output logic                 busy,
  output logic                 clear_done,
  output logic                 drop
);
  localparam int WW = $clog2(WIN + 1);
  localparam int SW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ISSUE, S_CLEAR} state_t;

  state_t             r_state;
  logic [WW-1:0]      r_win;
  logic               r_pend;
  logic [SW-1:0]      r_last;
  logic [NREQ-1:0]    r_grant;
  logic               r_we;
  logic [12:0]        r_addr;
  logic [2:0]         r_wdata;
  logic               r_busy;
  logic               r_done;
  logic               r_drop;

  stroke_req_t [NREQ-1:0] w_req;
  stroke_wr_t  [NREQ-1:0] w_wr;
  logic                   w_hit;
  logic [SW-1:0]          w_sel;
  logic [SW-1:0]          w_j;
  logic                   w_live;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign w_req[gi] = {req_x[10*gi +: 10], req_y[10*gi +: 10],
                        req_color[3*gi +: 3], req_erase[gi]};
    stroke_req_lane u_lane (.i_req(w_req[gi]), .o_wr(w_wr[gi]));
  end

  // Round-robin search starting one past the last serviced requester.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_j   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_j = SW'((32'(r_last) + k) % NREQ);
      if (!w_hit && req[w_j]) begin
        w_hit = 1'b1;
        w_sel = w_j;
      end
    end
  end

  // A refr_tick in the same cycle reopens the window, so it keeps arbitration alive.
  assign w_live = refr_tick || (r_win != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_win   <= '0;
      r_pend  <= 1'b0;
      r_last  <= SW'(NREQ - 1);
      r_grant <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_grant <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 1'b0;
      if (r_state != S_CLEAR && clear_req) r_pend <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (refr_tick) begin
            r_win   <= WW'(WIN);
            r_state <= S_ARB;
          end
        end
        S_ARB, S_ISSUE: begin
          if (refr_tick)         r_win <= WW'(WIN);
          else if (r_win != '0)  r_win <= r_win - 1'b1;
          if (!w_live) begin
            r_state <= S_IDLE;
          end else if (r_state == S_ISSUE) begin
            r_state <= S_ARB;
          end else if (r_pend) begin
            r_pend  <= 1'b0;
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
          end else if (w_hit) begin
            r_last  <= w_sel;
            r_grant <= NREQ'(1) << w_sel;
            r_we    <= w_wr[w_sel].ok;
            r_drop  <= !w_wr[w_sel].ok;
            r_addr  <= w_wr[w_sel].addr;
            r_wdata <= w_wr[w_sel].wdata;
            r_state <= S_ISSUE;
          end
        end
        S_CLEAR: begin
          if (r_addr == '1) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_addr <= r_addr + 13'd1;
            r_we   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign ram_we     = r_we;
  assign ram_addr   = r_addr;
  assign ram_wdata  = r_wdata;
  assign busy       = r_busy;
  assign clear_done = r_done;
  assign drop       = r_drop;
endmodule

// File: tb/tb_stroke_write_arbiter.sv
// Bench for stroke_write_arbiter: two instances (WIN=64 and WIN=4) on shared stimulus,
// compared every cycle against a behavioural model plus directed constant checks.
module tb_stroke_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        refr_tick, clear_req;
  logic [4:0]  req, req_erase;
  logic [49:0] req_x, req_y;
  logic [14:0] req_color;

  logic [4:0]  grant_a, grant_b;
  logic        we_a, we_b, busy_a, busy_b, done_a, done_b, drop_a, drop_b;
  logic [12:0] addr_a, addr_b;
  logic [2:0]  wdata_a, wdata_b;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stroke_write_arbiter #(.WIN(64), .NREQ(5)) u_dut_a (
    .clk(clk), .reset(reset), .refr_tick(refr_tick), .req(req), .req_x(req_x),
    .req_y(req_y), .req_color(req_color), .req_erase(req_erase), .clear_req(clear_req),
    .grant(grant_a), .ram_we(we_a), .ram_addr(addr_a), .ram_wdata(wdata_a),
    .busy(busy_a), .clear_done(done_a), .drop(drop_a));

  stroke_write_arbiter #(.WIN(4), .NREQ(5)) u_dut_b (
    .clk(clk), .reset(reset), .refr_tick(refr_tick), .req(req), .req_x(req_x),
    .req_y(req_y), .req_color(req_color), .req_erase(req_erase), .clear_req(clear_req),
    .grant(grant_b), .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(wdata_b),
    .busy(busy_b), .clear_done(done_b), .drop(drop_b));

  typedef struct {
    bit          active, issuing, pend, busy;
    int          win, clr, last;
    logic [4:0]  grant;
    logic        we, drop, done;
    logic [12:0] addr;
    logic [2:0]  wdata;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t rst_m();
    mdl_t n;
    n.active = 0; n.issuing = 0; n.pend = 0; n.busy = 0;
    n.win = 0; n.clr = -1; n.last = 4;
    n.grant = '0; n.we = 0; n.drop = 0; n.done = 0; n.addr = '0; n.wdata = '0;
    return n;
  endfunction

  // One clock of the arbiter rules: window bookkeeping, clear sweep, round-robin pick.
  function automatic mdl_t step(mdl_t m, int win_p);
    mdl_t n;
    int x, y, j;
    n = m;
    n.grant = '0; n.we = 0; n.drop = 0; n.done = 0;
    if (m.clr >= 0) begin
      if (m.clr == 8191) begin n.clr = -1; n.busy = 0; n.done = 1; end
      else begin n.clr = m.clr + 1; n.we = 1; n.addr = 13'(n.clr); end
      return n;
    end
    if (clear_req) n.pend = 1;
    if (!m.active) begin
      if (refr_tick) begin n.active = 1; n.win = win_p; end
      return n;
    end
    if (refr_tick) n.win = win_p;
    else if (m.win > 0) n.win = m.win - 1;
    if (!refr_tick && m.win == 0) begin n.active = 0; n.issuing = 0; return n; end
    if (m.issuing) begin n.issuing = 0; return n; end
    if (m.pend) begin
      n.pend = 0; n.active = 0; n.clr = 0; n.busy = 1; n.we = 1; n.addr = '0; n.wdata = '0;
      return n;
    end
    for (int k = 1; k <= 5; k++) begin
      j = (m.last + k) % 5;
      if (req[j]) begin
        x = int'(req_x[j*10 +: 10]);
        y = int'(req_y[j*10 +: 10]);
        n.last = j; n.issuing = 1;
        n.grant = 5'(1 << j);
        n.we = (x < 640 && y < 480);
        n.drop = !n.we;
        n.addr = 13'((y / 8 % 64) * 128 + (x / 8 % 128));
        n.wdata = req_color[j*3 +: 3];
`ifdef STROKE_ERASE_EN
        if (req_erase[j]) n.wdata = 3'b000;
`endif
        return n;
      end
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a();
    chk("A.grant", 32'(grant_a), 32'(ma.grant)); chk("A.we", 32'(we_a), 32'(ma.we));
    chk("A.addr", 32'(addr_a), 32'(ma.addr));    chk("A.wdata", 32'(wdata_a), 32'(ma.wdata));
    chk("A.busy", 32'(busy_a), 32'(ma.busy));    chk("A.done", 32'(done_a), 32'(ma.done));
    chk("A.drop", 32'(drop_a), 32'(ma.drop));
  endtask

  task automatic chk_b();
    chk("B.grant", 32'(grant_b), 32'(mb.grant)); chk("B.we", 32'(we_b), 32'(mb.we));
    chk("B.addr", 32'(addr_b), 32'(mb.addr));    chk("B.wdata", 32'(wdata_b), 32'(mb.wdata));
    chk("B.busy", 32'(busy_b), 32'(mb.busy));    chk("B.done", 32'(done_b), 32'(mb.done));
    chk("B.drop", 32'(drop_b), 32'(mb.drop));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (reset) begin ma = rst_m(); mb = rst_m(); end
    else begin ma = step(ma, 64); mb = step(mb, 4); end
    chk_a();
    chk_b();
  endtask

  task automatic set_lane(int i, int x, int y, logic [2:0] c, logic e);
    req_x[i*10 +: 10] = 10'(x);
    req_y[i*10 +: 10] = 10'(y);
    req_color[i*3 +: 3] = c;
    req_erase[i] = e;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; refr_tick = 0; clear_req = 0; req_erase = '0;
    cyc();
    reset = 1'b0;
  endtask

  function automatic int oh2i(logic [4:0] g);
    for (int i = 0; i < 5; i++) if (g[i]) return i;
    return -1;
  endfunction

  initial begin
    int na, nb, writes;
    bit seen;
    reset = 1'b1; refr_tick = 0; clear_req = 0; req = '0; req_erase = '0;
    req_x = '0; req_y = '0; req_color = '0;
    ma = rst_m(); mb = rst_m();
    #2;
    chk("rst.grant", 32'(grant_a), 0); chk("rst.we", 32'(we_a), 0);
    chk("rst.addr", 32'(addr_a), 0);   chk("rst.busy", 32'(busy_a), 0);
    cyc();
    reset = 1'b0;

    // single request, first grant
    req = 5'b00001; set_lane(0, 100, 50, 3'b101, 1'b0); refr_tick = 1;
    cyc();
    refr_tick = 0;
    cyc();
    chk("first.grant", 32'(grant_a), 32'h1); chk("first.we", 32'(we_a), 1);
    chk("first.addr", 32'(addr_a), {6'd6, 7'd12}); chk("first.wdata", 32'(wdata_a), 3'b101);
    req = '0;
    cyc();

    // all five requesting: rotation, one grant per two cycles; WIN=4 instance closes early
    do_reset();
    req = 5'b11111;
    for (int i = 0; i < 5; i++) set_lane(i, 16 * i + 3, 8 * i + 1, 3'(i + 1), 1'b0);
    refr_tick = 1; cyc(); refr_tick = 0;
    na = 0; nb = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (grant_a != '0) begin
        chk("rr.order", 32'(oh2i(grant_a)), 32'(na % 5));
        chk("rr.spacing", 32'(c % 2), 0);
        na++;
      end
      if (grant_b != '0) nb++;
    end
    chk("rr.count", 32'(na), 10);
    chk("win4.count5", 32'(nb), 2);

    // three pending with the short window
    do_reset();
    req = 5'b10110;
    refr_tick = 1; cyc(); refr_tick = 0;
    na = 0; nb = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (grant_a != '0) na++;
      if (grant_b != '0) nb++;
    end
    chk("win4.count3", 32'(nb), 2);
    chk("win64.count3", 32'(na), 6);

    // out-of-range coordinate
    do_reset();
    req = 5'b00100; set_lane(2, 700, 10, 3'b011, 1'b0);
    refr_tick = 1; cyc(); refr_tick = 0;
    cyc();
    chk("oor.grant", 32'(grant_a), 32'h4); chk("oor.we", 32'(we_a), 0);
    chk("oor.drop", 32'(drop_a), 1);
    req = '0;
    cyc();

    // eraser flag
    do_reset();
    req = 5'b00010; set_lane(1, 320, 240, 3'b111, 1'b1);
    refr_tick = 1; cyc(); refr_tick = 0;
    cyc();
    chk("erase.grant", 32'(grant_a), 32'h2);
    chk("erase.addr", 32'(addr_a), 32'd3880);
`ifdef STROKE_ERASE_EN
    chk("erase.wdata", 32'(wdata_a), 3'b000);
`else
    chk("erase.wdata", 32'(wdata_a), 3'b111);
`endif
    req = '0; req_erase = '0;
    cyc();

    // full clear with a request pending
    do_reset();
    req = 5'b00001; set_lane(0, 40, 40, 3'b110, 1'b0);
    clear_req = 1; refr_tick = 1; cyc(); clear_req = 0; refr_tick = 0;
    cyc();
    chk("clr.busy0", 32'(busy_a), 1); chk("clr.grant0", 32'(grant_a), 0);
    writes = 0; seen = 0;
    for (int c = 0; c < 8400 && !seen; c++) begin
      if (done_a) seen = 1;
      else begin
        if (we_a && wdata_a == 3'b000 && busy_a) writes++;
        cyc();
      end
    end
    chk("clr.done", 32'(seen), 1);
    chk("clr.writes", 32'(writes), 32'd8192);
    chk("clr.busy_end", 32'(busy_a), 0);
    for (int c = 0; c < 4; c++) cyc();
    chk("clr.idle_grant", 32'(grant_a), 0);

    // reset in the middle of a sweep
    do_reset();
    clear_req = 1; refr_tick = 1; cyc(); clear_req = 0; refr_tick = 0;
    cyc();
    for (int c = 0; c < 300 && addr_a != 13'd100; c++) cyc();
    chk("clr.reach100", 32'(addr_a), 32'd100);
    reset = 1'b1;
    #1;
    chk("midrst.busy", 32'(busy_a), 0); chk("midrst.we", 32'(we_a), 0);
    chk("midrst.addr", 32'(addr_a), 0);
    ma = rst_m(); mb = rst_m();
    cyc();
    reset = 1'b0;
    cyc();
    chk("midrst.idle", 32'(busy_a), 0);

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      refr_tick = ($urandom_range(0, 24) == 0);
      clear_req = ($urandom_range(0, 699) == 0);
      req = 5'($urandom);
      for (int i = 0; i < 5; i++)
        set_lane(i, int'($urandom_range(0, 767)), int'($urandom_range(0, 543)),
                 3'($urandom), 1'($urandom));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
